// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Round-robin Wishbone arbiter, N masters onto one slave, with
//            cyc-burst locking and per-transfer acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = DATA_W / 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        m_cyc_i,
    input  logic [N_MASTERS-1:0]        m_stb_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS*ADDR_W-1:0] m_adr_i,
    input  logic [N_MASTERS*DATA_W-1:0] m_data_i,
    input  logic [N_MASTERS*SEL_W-1:0]  m_sel_i,
    output logic [DATA_W-1:0]           m_data_o,
    output logic [N_MASTERS-1:0]        m_akn_o,
    output logic [N_MASTERS-1:0]        m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [ADDR_W-1:0]           s_adr_o,
    output logic [DATA_W-1:0]           s_data_o,
    output logic [SEL_W-1:0]            s_sel_o,
    input  logic [DATA_W-1:0]           s_data_i,
    input  logic                        s_akn_i,
    output logic [N_MASTERS-1:0]        grant_o
);

    localparam int                 c_IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [0:0]         c_IDLE     = 1'b0;
    localparam logic [0:0]         c_BUSY     = 1'b1;
    localparam logic [7:0]         c_TIMEOUT  = 8'(TIMEOUT);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N_MASTERS - 1);

    logic [0:0]           r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [c_IDX_W-1:0]   r_last;
    logic [7:0]           r_cnt;
    logic                 r_err;

    logic                 w_gcyc;
    logic                 w_gstb;
    logic                 w_gwe;
    logic [ADDR_W-1:0]    w_adr;
    logic [DATA_W-1:0]    w_data;
    logic [SEL_W-1:0]     w_sel;
    logic                 w_busy;
    logic                 w_arb;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win;
    logic [N_MASTERS-1:0] w_grant_nxt;
    logic                 w_hit;

    // One-hot grant makes an AND-OR mux; everything reads 0 while idle.
    always_comb begin
        w_gcyc = 1'b0;
        w_gstb = 1'b0;
        w_gwe  = 1'b0;
        w_adr  = '0;
        w_data = '0;
        w_sel  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_gcyc = w_gcyc | m_cyc_i[k];
                w_gstb = w_gstb | m_stb_i[k];
                w_gwe  = w_gwe  | m_we_i[k];
                w_adr  = w_adr  | m_adr_i[k*ADDR_W +: ADDR_W];
                w_data = w_data | m_data_i[k*DATA_W +: DATA_W];
                w_sel  = w_sel  | m_sel_i[k*SEL_W +: SEL_W];
            end
        end
    end

    assign w_busy  = (r_state == c_BUSY);
    assign w_arb   = !w_busy || !w_gcyc;

    // Winner is the requester at the smallest rotational distance past r_last.
    always_comb begin
        int d;
        int best;
        d           = 0;
        best        = N_MASTERS;
        w_win       = r_last;
        w_grant_nxt = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (m_cyc_i[k]) begin
                d = (k + N_MASTERS - 1 - int'(r_last)) % N_MASTERS;
                if (d < best) begin
                    best           = d;
                    w_win          = c_IDX_W'(k);
                    w_grant_nxt    = '0;
                    w_grant_nxt[k] = 1'b1;
                end
            end
        end
        w_found = (best < N_MASTERS);
    end

    assign s_cyc_o  = w_busy & w_gcyc;
    assign s_stb_o  = s_cyc_o & w_gstb & ~r_err;
    assign s_we_o   = w_busy & w_gwe;
    assign s_adr_o  = w_adr;
    assign s_data_o = w_data;
    assign s_sel_o  = w_sel;
    assign m_data_o = s_data_i;
    assign m_akn_o  = (s_akn_i & s_stb_o) ? r_grant : '0;
    assign m_err_o  = r_err ? r_grant : '0;
    assign grant_o  = r_grant;

    assign w_hit    = ((r_cnt + 8'd1) == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_last  <= c_LAST_RST;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_arb) begin
                r_state <= w_found ? c_BUSY : c_IDLE;
                r_grant <= w_grant_nxt;
                if (w_found) begin
                    r_last <= w_win;
                end
                r_cnt <= 8'd0;
                r_err <= 1'b0;
            end else if (s_akn_i) begin
                // An ack on the would-be timeout cycle takes priority.
                r_cnt <= 8'd0;
                r_err <= 1'b0;
            end else if (s_stb_o) begin
                if (w_hit) begin
                    r_cnt <= 8'd0;
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                    r_err <= 1'b0;
                end
            end else begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter
// Brief    : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_data;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   s_data_i;
    logic            s_akn;
    logic [DW-1:0]   m_data_o;
    logic [N-1:0]    m_akn_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_data_o;
    logic [SW-1:0]   s_sel_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_data_i(m_data), .m_sel_i(m_sel),
        .m_data_o(m_data_o), .m_akn_o(m_akn_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data_i), .s_akn_i(s_akn), .grant_o(grant_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_data = '0; m_sel = '0;
        s_data_i = '0; s_akn = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        m_cyc = '1; m_stb = '1; m_we = '1; s_akn = 1'b1;
        m_adr = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        m_data = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
        m_sel = '1;
        s_data_i = 16'hA5C3;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0000) begin
            failures++; $display("FAIL reset_grant: got %b want 0000", grant_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o});
        end
        checks++;
        if ({m_akn_o, m_err_o} !== 8'h00) begin
            failures++; $display("FAIL reset_akn_err: got %b want 00000000", {m_akn_o, m_err_o});
        end
        checks++;
        if ({s_adr_o, s_data_o, s_sel_o} !== 34'h0) begin
            failures++; $display("FAIL reset_payload: got %h want 0", {s_adr_o, s_data_o, s_sel_o});
        end
        checks++;
        if (m_data_o !== 16'hA5C3) begin
            failures++; $display("FAIL reset_rdata: got %h want a5c3", m_data_o);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int err_seen;
        err_seen = 0;
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[15:0] = 16'h0010; m_data[15:0] = 16'hBEEF; m_sel[1:0] = 2'b11;
        s_data_i = 16'h1234;
        settle();
        err_seen += int'(|m_err_o);
        checks++;
        if (grant_o !== 4'b0000) begin
            failures++; $display("FAIL single_latency: got %b want 0000", grant_o);
        end
        tick();
        settle();
        err_seen += int'(|m_err_o);
        checks++;
        if (grant_o !== 4'b0001) begin
            failures++; $display("FAIL single_grant: got %b want 0001", grant_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_data_o, s_sel_o} !== {3'b111, 16'h0010, 16'hBEEF, 2'b11}) begin
            failures++; $display("FAIL single_mux: got %b_%h_%h_%b want 111_0010_beef_11",
                                 {s_cyc_o, s_stb_o, s_we_o}, s_adr_o, s_data_o, s_sel_o);
        end
        checks++;
        if (m_akn_o !== 4'b0000) begin
            failures++; $display("FAIL single_akn_early: got %b want 0000", m_akn_o);
        end
        tick();
        s_akn = 1'b1;
        settle();
        err_seen += int'(|m_err_o);
        checks++;
        if ({m_akn_o, m_data_o} !== {4'b0001, 16'h1234}) begin
            failures++; $display("FAIL single_akn: got %b/%h want 0001/1234", m_akn_o, m_data_o);
        end
        tick();
        s_akn = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        settle();
        err_seen += int'(|m_err_o);
        checks++;
        if ({m_akn_o, s_cyc_o, grant_o} !== {4'b0000, 1'b0, 4'b0001}) begin
            failures++; $display("FAIL single_drop: got akn=%b cyc=%b grant=%b want 0000/0/0001",
                                 m_akn_o, s_cyc_o, grant_o);
        end
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0000) begin
            failures++; $display("FAIL single_release: got %b want 0000", grant_o);
        end
        checks++;
        if (err_seen !== 0) begin
            failures++; $display("FAIL single_no_err: got %0d err cycles want 0", err_seen);
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        m_cyc = 4'b0101;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0001) begin
            failures++; $display("FAIL cont_first: got %b want 0001", grant_o);
        end
        tick();
        m_cyc[0] = 1'b0;
        settle();
        checks++;
        if (s_cyc_o !== 1'b0) begin
            failures++; $display("FAIL cont_drop_comb: got %b want 0", s_cyc_o);
        end
        tick();
        settle();
        checks++;
        if ({grant_o, s_cyc_o} !== {4'b0100, 1'b1}) begin
            failures++; $display("FAIL cont_handover: got %b/%b want 0100/1", grant_o, s_cyc_o);
        end
        tick();
        m_cyc[0] = 1'b1;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0100) begin
            failures++; $display("FAIL cont_no_preempt: got %b want 0100", grant_o);
        end
        tick();
        m_cyc[2] = 1'b0;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0001) begin
            failures++; $display("FAIL cont_rotate: got %b want 0001", grant_o);
        end
        idle_inputs();
    endtask

    task automatic test_burst_lock();
        int acks;
        acks = 0;
        do_reset();
        m_cyc[1] = 1'b1;
        m_adr[31:16] = 16'h0200;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0010) begin
            failures++; $display("FAIL burst_grant: got %b want 0010", grant_o);
        end
        for (int t = 0; t < 6; t++) begin
            tick();
            m_cyc[0] = 1'b1;
            m_stb[1] = 1'b1;
            s_akn = (t % 2 == 1);
            settle();
            if (m_akn_o == 4'b0010) acks++;
            checks++;
            if (grant_o !== 4'b0010 || m_akn_o[0] !== 1'b0) begin
                failures++; $display("FAIL burst_lock: cycle %0d got grant=%b akn=%b want grant 0010 akn0 0",
                                     t, grant_o, m_akn_o);
            end
        end
        checks++;
        if (acks !== 3) begin
            failures++; $display("FAIL burst_acks: got %0d want 3", acks);
        end
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_akn = 1'b0;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0001) begin
            failures++; $display("FAIL burst_next: got %b want 0001", grant_o);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic exp_err;
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        for (int n = 1; n <= 10; n++) begin
            settle();
            exp_err = (n == TO + 1) || (n == 2 * TO + 2);
            checks++;
            if (m_err_o !== (exp_err ? 4'b0010 : 4'b0000) || s_stb_o !== !exp_err) begin
                failures++; $display("FAIL timeout: cycle %0d got err=%b stb=%b want err=%b stb=%b",
                                     n, m_err_o, s_stb_o, exp_err ? 4'b0010 : 4'b0000, !exp_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_ack_boundary();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        for (int n = 1; n <= 9; n++) begin
            s_akn = (n == TO);
            settle();
            checks++;
            if (m_akn_o !== ((n == TO) ? 4'b0001 : 4'b0000) ||
                m_err_o !== ((n == 2 * TO + 1) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL ack_boundary: cycle %0d got akn=%b err=%b", n, m_akn_o, m_err_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        settle();
        checks++;
        if (grant_o !== 4'b0010) begin
            failures++; $display("FAIL rstmid_pre: got %b want 0010", grant_o);
        end
        tick();
        rst = 1'b0;
        m_cyc[0] = 1'b1;
        tick();
        rst = 1'b1;
        s_akn = 1'b1;
        settle();
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, m_akn_o, m_err_o} !== 14'h0) begin
            failures++; $display("FAIL rstmid_abort: got grant=%b cyc=%b stb=%b akn=%b err=%b want all 0",
                                 grant_o, s_cyc_o, s_stb_o, m_akn_o, m_err_o);
        end
        tick();
        s_akn = 1'b0;
        m_stb[1] = 1'b0;
        settle();
        checks++;
        if ({grant_o, m_err_o} !== {4'b0001, 4'b0000}) begin
            failures++; $display("FAIL rstmid_regrant: got grant=%b err=%b want 0001/0000", grant_o, m_err_o);
        end
        idle_inputs();
    endtask

    // Model: granted index (-1 = none), last winner, count of stalled strobes.
    task automatic test_random();
        int mg, mlast, mwait, cand;
        logic merr, gcyc, e_stb, e_we;
        logic [N-1:0] e_grant;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_sel;
        do_reset();
        mg = -1; mlast = N - 1; mwait = 0; merr = 1'b0;
        for (int it = 0; it < 600; it++) begin
            rst = ($urandom_range(63) != 0);
            for (int k = 0; k < N; k++) begin
                if (m_cyc[k]) m_cyc[k] = ($urandom_range(7) != 0);
                else          m_cyc[k] = ($urandom_range(3) == 0);
                m_stb[k] = ($urandom_range(3) != 0);
            end
            m_we = N'($urandom);
            m_adr = {$urandom, $urandom};
            m_data = {$urandom, $urandom};
            m_sel = N*SW'($urandom);
            s_data_i = DW'($urandom);
            s_akn = ($urandom_range(2) == 0);
            settle();

            e_grant = '0; gcyc = 1'b0; e_we = 1'b0;
            e_adr = '0; e_data = '0; e_sel = '0;
            if (mg >= 0) begin
                e_grant[mg] = 1'b1;
                gcyc   = m_cyc[mg];
                e_we   = m_we[mg];
                e_adr  = m_adr[mg*AW +: AW];
                e_data = m_data[mg*DW +: DW];
                e_sel  = m_sel[mg*SW +: SW];
            end
            e_stb = gcyc && m_stb[mg] && !merr;

            checks++;
            if (grant_o !== e_grant) begin
                failures++; $display("FAIL rnd_grant: it %0d got %b want %b", it, grant_o, e_grant);
            end
            checks++;
            if ({s_cyc_o, s_stb_o, s_we_o} !== {gcyc, e_stb, e_we}) begin
                failures++; $display("FAIL rnd_ctrl: it %0d got %b want %b", it,
                                     {s_cyc_o, s_stb_o, s_we_o}, {gcyc, e_stb, e_we});
            end
            checks++;
            if (m_akn_o !== ((e_stb && s_akn) ? e_grant : 4'b0000)) begin
                failures++; $display("FAIL rnd_akn: it %0d got %b want %b", it, m_akn_o,
                                     (e_stb && s_akn) ? e_grant : 4'b0000);
            end
            checks++;
            if (m_err_o !== (merr ? e_grant : 4'b0000)) begin
                failures++; $display("FAIL rnd_err: it %0d got %b want %b", it, m_err_o,
                                     merr ? e_grant : 4'b0000);
            end
            checks++;
            if ({s_adr_o, s_data_o, s_sel_o, m_data_o} !== {e_adr, e_data, e_sel, s_data_i}) begin
                failures++; $display("FAIL rnd_payload: it %0d got %h want %h", it,
                                     {s_adr_o, s_data_o, s_sel_o, m_data_o}, {e_adr, e_data, e_sel, s_data_i});
            end

            if (!rst) begin
                mg = -1; mlast = N - 1; mwait = 0; merr = 1'b0;
            end else if (mg < 0 || !gcyc) begin
                mg = -1;
                for (int s = 1; s <= N; s++) begin
                    cand = (mlast + s) % N;
                    if (mg < 0 && m_cyc[cand]) mg = cand;
                end
                if (mg >= 0) mlast = mg;
                mwait = 0; merr = 1'b0;
            end else if (s_akn) begin
                mwait = 0; merr = 1'b0;
            end else if (e_stb) begin
                mwait++;
                merr = (mwait == TO);
                if (merr) mwait = 0;
            end else begin
                merr = 1'b0;
            end
            tick();
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_burst_lock();
        test_timeout();
        test_ack_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised round-robin Wishbone arbiter connecting N_MASTERS bus masters (CPU fetch port, CPU data port, testbench/DMA agents) to one shared Wishbone slave port. It generalises the 16-bit single-master bus to configurable address/data width, byte selects and channel count. It adds fair arbitration, bus locking for the whole `cyc` burst, and a per-transfer acknowledge timeout that returns an error to the stalled master.

## Interface
Parameters:
- N_MASTERS, 2, number of master ports (2..8)
- ADDR_W, 16, address width
- DATA_W, 16, data width (multiple of 8)
- SEL_W, DATA_W/8, byte-select width
- TIMEOUT, 15, cycles of `stb` without `akn` before error (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- m_cyc_i  in  N_MASTERS  per-master cycle request
- m_stb_i  in  N_MASTERS  per-master strobe
- m_we_i  in  N_MASTERS  per-master write enable (1 = write)
- m_adr_i  in  N_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
- m_data_i  in  N_MASTERS*DATA_W  packed write data
- m_sel_i  in  N_MASTERS*SEL_W  packed byte selects
- m_data_o  out  DATA_W  read data, broadcast to all masters
- m_akn_o  out  N_MASTERS  acknowledge, only to the granted master
- m_err_o  out  N_MASTERS  timeout error pulse, only to the granted master
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side controls
- s_adr_o  out  ADDR_W  slave address
- s_data_o  out  DATA_W  slave write data
- s_sel_o  out  SEL_W  slave byte selects
- s_data_i  in  DATA_W  slave read data
- s_akn_i  in  1  slave acknowledge
- grant_o  out  N_MASTERS  one-hot current grant, 0 when idle

## Operation
- FSM has two states:
  - IDLE: no grant.
  - BUSY: grant register holds one master.
- Arbitration at each rising edge occurs when the state is IDLE, or when the state is BUSY and the granted master's `m_cyc_i` is 0.
  - The winner is the first asserted `m_cyc_i` searching from (last_grant+1) mod N_MASTERS upward with wrap.
  - If a winner exists: state BUSY, grant and last_grant are updated.
  - If no winner exists: state IDLE, grant is 0.
- The grant is held for as long as the granted `m_cyc_i` stays 1. Other requests cannot preempt it.
- Slave outputs are a combinational mux of the granted master's signals.
  - `s_cyc_o` = BUSY & granted cyc.
  - `s_stb_o` = BUSY & granted cyc & granted stb & !err_pulse.
- `m_akn_o[g]` = `s_akn_i` & `s_stb_o`. All other bits are 0. `m_data_o` = `s_data_i`, unconditionally.
- Timeout counter (8 bits):
  - Increments each cycle in which `s_stb_o`=1 and `s_akn_i`=0.
  - Clears on `s_akn_i`, on a grant change, or when the count reaches TIMEOUT.
  - When the count reaches TIMEOUT, `err_pulse` is registered for one cycle.
  - During that cycle `m_err_o[g]`=1 and `s_stb_o` is forced 0. The master may retry or drop `cyc`.
- If `s_akn_i` arrives in the same cycle the counter would hit TIMEOUT, the ack wins: no error, counter clears.

## Timing
- Reset (rst=0 sampled at an edge):
  - State IDLE, grant 0, last_grant = N_MASTERS-1 (master 0 wins first), counter 0, err_pulse 0.
  - All outputs 0 in the following cycle. `m_data_o` follows `s_data_i`.
- Reset mid-transfer aborts the grant immediately. No ack or error is generated for the aborted transfer.
- Grant latency: `m_cyc_i` first sampled 1 at edge t → `grant_o`, `s_cyc_o` high after edge t (one cycle after the request is presented).
- Handover: granted `cyc` drops in cycle c → `s_cyc_o` 0 during c (combinational). The next master is granted after the edge ending c, so there are no dead cycles beyond c.
- Ack path is combinational: zero added latency from `s_akn_i` to `m_akn_o`.
- Error pulse is exactly 1 cycle, asserted TIMEOUT cycles after the first unacknowledged `s_stb_o` cycle.

## Test plan
- Single master, N=2: M0 issues a write to adr 0x0010, data 0xBEEF, sel 2'b11; slave acks after 2 cycles → `grant_o`=01 one cycle after the request; s_adr_o=0x0010, s_data_o=0xBEEF; `m_akn_o`=01 for exactly 1 cycle; `m_err_o` stays 0.
- Contention, N=4: M0 and M2 assert `cyc` in the same cycle after reset → M0 granted. On M0 `cyc` drop, M2 is granted on the next edge. A new M0 request is then served only after M2 completes (rotation 0→2→0).
- Burst lock: M1 holds `cyc` for 3 stb/akn transfers while M0 requests continuously → `grant_o` stays 10 throughout; M0 is granted on the edge after M1 `cyc` drops.
- Timeout, TIMEOUT=4: slave never acks → `m_err_o[g]`=1 exactly in the 5th cycle after the first `stb`, with `s_stb_o`=0 in that cycle. A retry then restarts the count from 0.
- Ack at boundary: the ack arrives in the cycle the count equals TIMEOUT-1 → `m_akn_o` pulses and no error occurs.
- Reset mid-burst: rst=0 for 1 cycle while M1 is granted with `stb` pending → all outputs 0 after the edge. M0 and M1 both requesting after reset → M0 granted.
